// File: rtl/periph_timer_pkg.sv
// periph_timer_pkg: register word offsets and CTRL bit positions
// shared by the timer responder and other I/O peripherals.
package periph_timer_pkg;

    localparam logic [2:0] TMR_CTRL   = 3'd0;
    localparam logic [2:0] TMR_PRESC  = 3'd1;
    localparam logic [2:0] TMR_CMP    = 3'd2;
    localparam logic [2:0] TMR_COUNT  = 3'd3;
    localparam logic [2:0] TMR_STATUS = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

endpackage

// File: rtl/periph_timer_bus_rd_handshake.sv
// Two-cycle read handshake for I/O responders.
// Ports: i_clk, i_rst, i_hit, i_re in; o_rd_done, o_rdy out.
module periph_timer_bus_rd_handshake (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_hit,
    input  logic i_re,
    output logic o_rd_done,
    output logic o_rdy
);

    // Set on the first cycle of a read, clear on the next edge,
    // so a held read strobe completes every second cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_done <= 1'b0;
        end else begin
            o_rd_done <= i_hit & i_re & ~o_rd_done;
        end
    end

    // Reset releases the stall at once, even with i_re still held.
    assign o_rdy = ~(i_hit & i_re & ~o_rd_done & ~i_rst);

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped 16-bit timer with prescaler, compare, one-shot/auto-reload, level IRQ.
// Ports: i_clk, i_rst, i_addr/i_sel/i_we/i_re/i_wdata bus in; o_rdata, o_rdy, o_irq out; i_irq_ack in.
module periph_timer
    import periph_timer_pkg::*;
#(
    parameter logic [15:0] P_BASE = 16'h8010,
    parameter logic [15:0] P_MASK = 16'hFFF0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_rdy,
    output logic        o_irq,
    input  logic        i_irq_ack
);

    logic        hit;
    logic [2:0]  woff;
    logic        rd_done;
    logic        rd_cap;
    logic        wr;
    logic [2:0]  ctrl;
    logic [15:0] presc;
    logic [15:0] cmp;
    logic [15:0] count;
    logic        match;
    logic [15:0] pcnt;
    logic        tick;
    logic        at_cmp;
    logic        match_clr;
    logic [15:0] rd_mux;

    assign hit    = i_sel & ((i_addr & P_MASK) == P_BASE);
    assign woff   = i_addr[3:1];
    assign rd_cap = hit & i_re & ~rd_done;
    assign wr     = hit & i_we;
    assign tick   = ctrl[CTRL_EN] & (pcnt == presc);
    assign at_cmp = (count == cmp);

    assign match_clr = (wr & (woff == TMR_STATUS) & i_wdata[0])
                     | i_irq_ack;

    periph_timer_bus_rd_handshake u_rd_hs (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_hit     (hit),
        .i_re      (i_re),
        .o_rd_done (rd_done),
        .o_rdy     (o_rdy)
    );

    always_comb begin
        rd_mux = '0;
        unique case (woff)
            TMR_CTRL:   rd_mux = {13'd0, ctrl};
            TMR_PRESC:  rd_mux = presc;
            TMR_CMP:    rd_mux = cmp;
            TMR_COUNT:  rd_mux = count;
            TMR_STATUS: rd_mux = {15'd0, match};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl    <= '0;
            presc   <= '0;
            cmp     <= 16'hFFFF;
            count   <= '0;
            match   <= 1'b0;
            pcnt    <= '0;
            o_irq   <= 1'b0;
            o_rdata <= '0;
        end else begin
            // Data is only non-zero while rd_done is high.
            o_rdata <= rd_cap ? rd_mux : 16'd0;
            o_irq   <= match & ctrl[CTRL_IE];

            // PRESC writes leave pcnt alone; a smaller PRESC
            // lets pcnt run through the 16-bit wrap first.
            if (!ctrl[CTRL_EN] || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 16'd1;
            end

            if (tick) begin
                if (!at_cmp) begin
                    count <= count + 16'd1;
                end else if (ctrl[CTRL_AUTO]) begin
                    count <= '0;
                end else begin
                    ctrl[CTRL_EN] <= 1'b0;
                end
            end

            // A set on this edge wins over any clear.
            if (tick && at_cmp) begin
                match <= 1'b1;
            end else if (match_clr) begin
                match <= 1'b0;
            end

            // CPU writes override the tick update of the same register.
            if (wr) begin
                unique case (woff)
                    TMR_CTRL:  ctrl  <= i_wdata[2:0];
                    TMR_PRESC: presc <= i_wdata;
                    TMR_CMP:   cmp   <= i_wdata;
                    TMR_COUNT: count <= i_wdata;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_periph_timer.sv
// Scoreboard bench for periph_timer: reads push expected data,
// a negedge monitor pops and compares when a read completes.
module tb_periph_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [15:0] wdata = '0;
    logic        ack = 1'b0;
    logic [15:0] rdata;
    logic        rdy;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    localparam logic [15:0] A_CTRL   = 16'h8010;
    localparam logic [15:0] A_PRESC  = 16'h8012;
    localparam logic [15:0] A_CMP    = 16'h8014;
    localparam logic [15:0] A_COUNT  = 16'h8016;
    localparam logic [15:0] A_STATUS = 16'h8018;
    localparam logic [15:0] A_RSV5   = 16'h801A;
    localparam logic [15:0] A_MISS   = 16'h8020;

    periph_timer dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_addr    (addr),
        .i_sel     (sel),
        .i_we      (we),
        .i_re      (re),
        .i_wdata   (wdata),
        .o_rdata   (rdata),
        .o_rdy     (rdy),
        .o_irq     (irq),
        .i_irq_ack (ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && sel && re && rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got %h want none", rdata);
            end else begin
                automatic logic [15:0] e = exp_q.pop_front();
                automatic string t = tag_q.pop_front();
                if (rdata !== e) begin
                    n_err++;
                    $display("FAIL rd %s: got %h want %h", t, rdata, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr = a;
        wdata = d;
        sel = 1'b1;
        we = 1'b1;
        @(posedge clk);
        #1;
        sel = 1'b0;
        we = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [15:0] a,
                      input logic [15:0] e, input int stalls_exp);
        int stalls;
        bit done;
        stalls = 0;
        done = 1'b0;
        exp_q.push_back(e);
        tag_q.push_back(nm);
        addr = a;
        sel = 1'b1;
        re = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (rdy) done = 1'b1;
            else stalls++;
        end
        if (!done) begin
            void'(exp_q.pop_back());
            void'(tag_q.pop_back());
        end
        @(posedge clk);
        #1;
        sel = 1'b0;
        re = 1'b0;
        chk({nm, "_stall"}, 16'(stalls), 16'(stalls_exp));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", {15'd0, rdy}, 16'd1);
        chk("rst_rdata", rdata, 16'd0);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        rst = 1'b0;

        rd("r_ctrl", A_CTRL, 16'h0000, 1);
        rd("r_presc", A_PRESC, 16'h0000, 1);
        rd("r_cmp", A_CMP, 16'hFFFF, 1);
        rd("r_count", A_COUNT, 16'h0000, 1);
        rd("r_status", A_STATUS, 16'h0000, 1);
        rd("r_off5", 16'h801A, 16'h0000, 1);
        rd("r_off6", 16'h801C, 16'h0000, 1);
        rd("r_off7", 16'h801E, 16'h0000, 1);

        // Auto-reload, PRESC=3: COUNT steps on E4, E8, ...
        wr(A_PRESC, 16'd3);
        wr(A_CMP, 16'd5);
        wr(A_CTRL, 16'h0007);
        idle(3);
        rd("ar_e3", A_COUNT, 16'd0, 1);
        rd("ar_e5", A_COUNT, 16'd1, 1);
        rd("ar_e7", A_COUNT, 16'd1, 1);
        rd("ar_e9", A_COUNT, 16'd2, 1);
        idle(12);
        chk("ar_irq_pre", {15'd0, irq}, 16'd0);
        rd("ar_st_e23", A_STATUS, 16'd0, 1);
        chk("ar_irq_post", {15'd0, irq}, 16'd1);
        rd("ar_st_e25", A_STATUS, 16'd1, 1);
        rd("ar_wrap_e27", A_COUNT, 16'd0, 1);
        rd("ar_run_e29", A_COUNT, 16'd1, 1);
        wr(A_CTRL, 16'h0000);
        wr(A_STATUS, 16'h0001);

        // One-shot, PRESC=0, CMP=2
        wr(A_COUNT, 16'd0);
        wr(A_CMP, 16'd2);
        wr(A_PRESC, 16'd0);
        wr(A_CTRL, 16'h0005);
        idle(4);
        rd("os_status", A_STATUS, 16'd1, 1);
        rd("os_count", A_COUNT, 16'd2, 1);
        rd("os_ctrl", A_CTRL, 16'h0004, 1);
        chk("os_irq", {15'd0, irq}, 16'd1);

        // MATCH set and W1C on the same edge
        wr(A_STATUS, 16'h0001);
        wr(A_COUNT, 16'd0);
        wr(A_CTRL, 16'h0005);
        idle(2);
        wr(A_STATUS, 16'h0001);
        rd("w1c_race", A_STATUS, 16'd1, 1);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        chk("ack_irq_lag", {15'd0, irq}, 16'd1);
        idle(1);
        chk("ack_irq_drop", {15'd0, irq}, 16'd0);
        rd("ack_status", A_STATUS, 16'd0, 1);

        // COUNT write beats the tick increment
        wr(A_CMP, 16'h8000);
        wr(A_CTRL, 16'h0001);
        wr(A_COUNT, 16'h1234);
        rd("wr_beats_tick", A_COUNT, 16'h1234, 1);
        wr(A_CTRL, 16'h0000);

        // Wrap past FFFF when CMP=FFFE
        wr(A_CMP, 16'hFFFE);
        wr(A_COUNT, 16'hFFFF);
        wr(A_CTRL, 16'h0001);
        idle(1);
        rd("wrap_count", A_COUNT, 16'h0000, 1);
        rd("wrap_nomatch", A_STATUS, 16'h0000, 1);
        wr(A_CTRL, 16'h0000);

        // Misses and reserved offsets
        rd("miss_rd", A_MISS, 16'h0000, 0);
        wr(A_MISS, 16'h0007);
        rd("miss_wr", A_CTRL, 16'h0000, 1);
        wr(A_RSV5, 16'hFFFF);
        rd("rsv5_wr", A_RSV5, 16'h0000, 1);

        // Reset during the stall cycle of a read
        wr(A_CMP, 16'h1234);
        addr = A_CMP;
        sel = 1'b1;
        re = 1'b1;
        #1;
        chk("rr_stall", {15'd0, rdy}, 16'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rr_rdy", {15'd0, rdy}, 16'd1);
        sel = 1'b0;
        re = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd("rr_cmp", A_CMP, 16'hFFFF, 1);
        rd("rr_count", A_COUNT, 16'h0000, 1);
        rd("rr_ctrl", A_CTRL, 16'h0000, 1);

        idle(2);
        chk("sb_drain", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
